instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries; legal values 2 or 4.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr  output  32  fetch byte address, word aligned.
REQ-007 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid.
REQ-009 SHALL have port imem_rdata  input  32  instruction word.
REQ-010 SHALL have port dec_valid  output  1  instruction presented to controller.
REQ-011 SHALL have port dec_ready  input  1  controller accepts instruction.
REQ-012 SHALL have ports dec_instr  output  32, dec_pc  output  32, dec_opcode  output  7, dec_f3  output  3, dec_f7  output  7: buffer head word, its PC, and fields [6:0], [14:12], [31:25].
REQ-013 SHALL have ports br_taken  input  1 and br_target  input  32: redirect request and target.
REQ-014 SHALL have port fetch_err  output  1  misaligned redirect flag (see Configuration).

Function
REQ-015 SHALL keep at most one request outstanding (granted, not yet responded).
REQ-016 SHALL assert imem_req only when buffer occupancy plus outstanding count < BUF_DEPTH; imem_req and imem_addr held stable until imem_gnt.
REQ-017 SHALL advance fetch PC by 4 on each grant; 32-bit wrap from 32'hFFFF_FFFC to 0.
REQ-018 SHALL write imem_rdata with its PC into the buffer on imem_rvalid; visible at dec_valid the next cycle (zero-wait memory: first dec_valid 2 cycles after first imem_req).
REQ-019 SHALL pop the head when dec_valid && dec_ready; push and pop in the same cycle leave occupancy unchanged.
REQ-020 SHALL hold dec_* outputs stable while dec_valid && !dec_ready.
REQ-021 SHALL use states RUN (normal), STALL (buffer full, no request), FLUSH (redirect pending with outstanding response); RUN->STALL when occupancy+outstanding == BUF_DEPTH, STALL->RUN on pop.
REQ-022 SHALL on br_taken: empty buffer and deassert dec_valid next cycle, load fetch PC with br_target, drop any un-granted request.
REQ-023 SHALL on br_taken with a response outstanding enter FLUSH, discard that response, issue no request until it arrives, then return to RUN.
REQ-024 SHALL discard imem_rvalid data arriving in the same cycle as br_taken.
REQ-025 SHALL give br_taken priority over dec_ready pop and over imem_gnt in the same cycle; a grant coinciding with br_taken counts as outstanding and is flushed.
REQ-026 SHALL ignore br_taken in FLUSH except updating the fetch PC to the newest br_target.

Reset
REQ-027 SHALL on rst_n low immediately set fetch PC=RESET_PC, state RUN, buffer empty, outstanding=0, imem_req=0, dec_valid=0, dec_* data=0, fetch_err=0.
REQ-028 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after rst_n release; reset mid-transaction abandons the outstanding response.

Configuration
REQ-029 SHALL with FETCH_ALIGN_CHK_EN defined: on br_taken with br_target[1:0]!=0, set fetch_err sticky until reset, stop issuing requests, let buffer drain.
REQ-030 SHALL without FETCH_ALIGN_CHK_EN: tie fetch_err to 0, force br_target[1:0] to 0 and redirect normally.

Verification
REQ-031 Reset release, zero-wait memory returning addr as data, dec_ready=1 -> dec_pc 0,4,8,... one per cycle after 2-cycle latency.
REQ-032 dec_ready=0 for 10 cycles -> buffer fills to BUF_DEPTH, imem_req low, dec_instr stable; dec_ready=1 -> streaming resumes without loss or duplication.
REQ-033 br_taken target 32'h100 with response outstanding (3-cycle memory) -> stale word dropped, next dec_pc 32'h100.
REQ-034 br_taken coincident with imem_rvalid and dec_ready -> no pop, data discarded, dec_valid low next cycle.
REQ-035 FETCH_ALIGN_CHK_EN defined, br_target 32'h102 -> fetch_err=1, no further imem_req; undefined -> fetch from 32'h100.
REQ-036 Fetch PC at 32'hFFFF_FFFC -> next imem_addr 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requests feeding a small instruction buffer.
// Define FETCH_ALIGN_CHK_EN to flag misaligned redirect targets instead of silently aligning them.
//
// state | meaning
// RUN   | normal fetching, requests issued while buffer space remains
// STALL | buffer plus in-flight word fills BUF_DEPTH, request only alongside a pop
// FLUSH | redirect taken with a response still in flight; that response is dropped
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [6:0]  dec_opcode,
  output logic [2:0]  dec_f3,
  output logic [6:0]  dec_f7,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fetch_err
);

  localparam int PW = (BUF_DEPTH == 4) ? 2 : 1;
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

  state_t        state;
  logic          live;
  logic          outstanding;
  logic          err;
  logic [31:0]   fetch_pc;
  logic [31:0]   out_pc;
  logic [31:0]   tgt;
  logic          misaligned;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] level;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   ibuf_instr [BUF_DEPTH];
  logic [31:0]   ibuf_pc    [BUF_DEPTH];
  logic          grant;
  logic          redirect;
  logic          push;
  logic          pop;
  logic          out_nxt;

`ifdef FETCH_ALIGN_CHK_EN
  assign tgt        = br_target;
  assign misaligned = |br_target[1:0];
  assign fetch_err  = err;
`else
  assign tgt        = br_target & 32'hFFFF_FFFC;
  assign misaligned = 1'b0;
  assign fetch_err  = 1'b0;
`endif

  always_comb begin
    grant     = imem_req & imem_gnt;
    redirect  = br_taken & (state != FLUSH);
    pop       = dec_valid & dec_ready & ~br_taken;
    push      = outstanding & imem_rvalid & ~br_taken & (state != FLUSH);
    level     = count + CW'(outstanding) - CW'(pop);
    count_nxt = count + CW'(push) - CW'(pop);
    out_nxt   = grant | (outstanding & ~imem_rvalid);
  end

  // Request is combinational on this cycle's pop and response so a depth-2 buffer streams one word per cycle.
  assign imem_req = live & ~err & (state != FLUSH) & (~outstanding | imem_rvalid)
                    & (level < CW'(BUF_DEPTH));
  assign imem_addr = fetch_pc;

  assign dec_valid  = (count != '0);
  assign dec_instr  = ibuf_instr[rd_ptr];
  assign dec_pc     = ibuf_pc[rd_ptr];
  assign dec_opcode = dec_instr[6:0];
  assign dec_f3     = dec_instr[14:12];
  assign dec_f7     = dec_instr[31:25];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      live        <= 1'b0;
      outstanding <= 1'b0;
      err         <= 1'b0;
      fetch_pc    <= RESET_PC;
      out_pc      <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        ibuf_instr[i] <= '0;
        ibuf_pc[i]    <= '0;
      end
    end else begin
      live <= 1'b1;
      if (grant) out_pc <= fetch_pc;
      if (redirect) begin
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        fetch_pc    <= tgt;
        outstanding <= out_nxt;
        state       <= out_nxt ? FLUSH : RUN;
        if (misaligned) err <= 1'b1;
      end else if (state == FLUSH) begin
        // Late redirects only retarget; a misaligned one must still block fetching.
        if (br_taken) begin
          fetch_pc <= tgt;
          if (misaligned) err <= 1'b1;
        end
        if (imem_rvalid) begin
          outstanding <= 1'b0;
          state       <= RUN;
        end
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        outstanding <= out_nxt;
        count       <= count_nxt;
        if (push) begin
          ibuf_instr[wr_ptr] <= imem_rdata;
          ibuf_pc[wr_ptr]    <= out_pc;
          wr_ptr             <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        state <= ((count_nxt + CW'(out_nxt)) == CW'(BUF_DEPTH)) ? STALL : RUN;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic against
// a program-order reference model and a single-outstanding memory model.
module tb_instr_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [6:0]  dec_opcode;
  logic [2:0]  dec_f3;
  logic [6:0]  dec_f7;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fetch_err;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_opcode(dec_opcode), .dec_f3(dec_f3), .dec_f7(dec_f7),
    .br_taken(br_taken), .br_target(br_target), .fetch_err(fetch_err)
  );

  int errors = 0;
  int checks = 0;

  // reference model: program order, fetch order, memory
  logic [31:0] exp_pc, fetch_exp, mem_addr;
  logic        mem_busy;
  int          mem_cnt, lat;
  bit          lat_rand;
  logic        prev_pend, prev_br, prev_hold;
  logic [31:0] prev_addr, prev_dpc, prev_dinstr;
  int          grants, pops, cyc;
  logic        last_grant, last_pop, last_rvalid, last_dvalid, last_req;
  logic [31:0] last_grant_addr, last_pop_pc;
  logic        seen_wrap;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", dec_valid, 1'b0);
    chk32("rst_instr", dec_instr, 32'h0);
    chk32("rst_pc", dec_pc, 32'h0);
    chk32("rst_fields", {15'h0, dec_opcode, dec_f3, dec_f7}, 32'h0);
    chk1("rst_err", fetch_err, 1'b0);
  endtask

  task automatic model_reset();
    exp_pc = 32'h0; fetch_exp = 32'h0; mem_busy = 1'b0; mem_cnt = 0;
    prev_pend = 1'b0; prev_br = 1'b0; prev_hold = 1'b0;
  endtask

  task automatic cycle(input logic rdy, input logic br, input logic [31:0] tgt, input logic gnt);
    logic rv, gr, pp;
    logic [31:0] w;
    @(negedge clk);
    rv = mem_busy && (mem_cnt == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? word_of(mem_addr) : $urandom();
    dec_ready = rdy; br_taken = br; br_target = tgt; imem_gnt = gnt;
    #1;
    gr = imem_req && gnt;
    pp = dec_valid && rdy && !br;
    if (prev_pend && !prev_br) begin
      chk1("req_hold", imem_req, 1'b1);
      chk32("addr_hold", imem_addr, prev_addr);
    end
    if (imem_req) chk1("addr_align", imem_addr[1:0] == 2'b00, 1'b1);
    if (prev_br) chk1("flush_valid", dec_valid, 1'b0);
    if (prev_hold && !prev_br) begin
      chk1("hold_valid", dec_valid, 1'b1);
      chk32("hold_pc", dec_pc, prev_dpc);
      chk32("hold_instr", dec_instr, prev_dinstr);
    end
    if (gr) begin
      chk32("fetch_addr", imem_addr, fetch_exp);
      chk1("one_outstanding", !mem_busy || rv, 1'b1);
    end
    if (pp) begin
      w = word_of(exp_pc);
      chk32("dec_pc", dec_pc, exp_pc);
      chk32("dec_instr", dec_instr, w);
      chk32("dec_fields", {15'h0, dec_opcode, dec_f3, dec_f7}, {15'h0, w[6:0], w[14:12], w[31:25]});
      exp_pc += 32'd4;
      pops++;
      last_pop_pc = dec_pc;
    end
    if (gr) begin
      grants++;
      fetch_exp += 32'd4;
      if (last_grant_addr == 32'hFFFF_FFFC && imem_addr == 32'h0) seen_wrap = 1'b1;
      last_grant_addr = imem_addr;
    end
    if (br) begin
      exp_pc    = tgt & 32'hFFFF_FFFC;
      fetch_exp = tgt & 32'hFFFF_FFFC;
    end
    if (rv) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (gr) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = lat_rand ? int'($urandom_range(0, 3)) : lat;
    end
    prev_pend = imem_req && !gnt; prev_addr = imem_addr; prev_br = br;
    prev_hold = dec_valid && !rdy; prev_dpc = dec_pc; prev_dinstr = dec_instr;
    last_grant = gr; last_pop = pp; last_rvalid = rv; last_dvalid = dec_valid; last_req = imem_req;
    cyc++;
  endtask

  initial begin
    int first_req, first_dv, g0, p0;
    logic got, r_rdy, r_br, r_gnt;
    logic [31:0] r_tgt;

    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    dec_ready = 1'b0; br_taken = 1'b0; br_target = '0;
    grants = 0; pops = 0; cyc = 0; lat = 0; lat_rand = 1'b0; seen_wrap = 1'b0;
    last_grant_addr = 32'h0; last_pop_pc = 32'h0; mem_addr = 32'h0;
    model_reset();

    #23;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // streaming from reset with zero-wait memory
    first_req = -1; first_dv = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      if (first_req < 0 && last_req) first_req = cyc;
      if (first_dv < 0 && last_dvalid) first_dv = cyc;
    end
    chk32("first_req_cycle", 32'(first_req), 32'd1);
    chk32("first_dec_latency", 32'(first_dv - first_req), 32'd2);
    chk32("stream_pops", 32'(pops), 32'd10);

    // consumer stall fills the buffer
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk32("fill_inflight", 32'(grants - pops), 32'(DEPTH));
    chk1("stall_req", last_req, 1'b0);
    chk1("stall_valid", last_dvalid, 1'b1);
    p0 = pops;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk32("resume_pops", 32'(pops - p0), 32'd10);

    // redirect with a response outstanding on 3-cycle memory
    lat = 2;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      got = last_grant;
    end
    chk1("flush_setup", got, 1'b1);
    cycle(1'b1, 1'b1, 32'h100, 1'b1);
    p0 = pops; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      got = (pops != p0);
    end
    chk1("flush_seen", got, 1'b1);
    chk32("flush_first_pc", last_pop_pc, 32'h100);

    // redirect coinciding with response and pop
    lat = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h200, 1'b1);
    chk1("coinc_setup", last_rvalid && last_dvalid, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk1("coinc_valid_low", last_dvalid, 1'b0);

    // address wrap at the top of the space
    cycle(1'b1, 1'b1, 32'hFFFF_FFF0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk1("wrap_seen", seen_wrap, 1'b1);

    // randomized traffic
    lat_rand = 1'b1;
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      r_rdy = ($urandom_range(0, 3) != 0);
      r_br  = ($urandom_range(0, 39) == 0);
      r_gnt = ($urandom_range(0, 3) != 0);
      r_tgt = $urandom() & 32'hFFFF_FFFC;
      cycle(r_rdy, r_br, r_tgt, r_gnt);
    end
    chk1("random_progress", (pops - p0) > 200, 1'b1);
    lat_rand = 1'b0;

    // misaligned redirect
    lat = 0;
    cycle(1'b1, 1'b1, 32'h102, 1'b1);
`ifdef FETCH_ALIGN_CHK_EN
    g0 = grants;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk1("align_err", fetch_err, 1'b1);
    chk32("align_no_req", 32'(grants - g0), 32'd0);
`else
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      got = last_grant;
    end
    chk1("misalign_grant", got, 1'b1);
    chk32("misalign_addr", last_grant_addr, 32'h100);
    chk1("misalign_no_err", fetch_err, 1'b0);
`endif

    // reset while a response is in flight
    lat = 2;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      got = last_grant;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset();
    model_reset();
    lat = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pops;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk32("post_reset_pops", 32'(pops - p0), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
